// File: rtl/conv_result_packer.sv
// Requantizes NUM_PER_CYCLE signed accumulator lanes to 8-bit, packs them into one
// word per beat and queues it with row/frame tags. Define PACKER_RELU_EN to clamp negatives to 0.
module conv_requant_lane #(
    parameter int ACC_WIDTH = 17,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [4:0]           shift,
    input  logic [ACC_WIDTH-1:0] x,
    output logic [OUT_WIDTH-1:0] q
);
    localparam int SW = ACC_WIDTH + 1;
    localparam logic signed [SW-1:0] MAXV = SW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (OUT_WIDTH - 1)));

    logic signed [SW-1:0] xs, rnd, shifted, v_q;

    // One extra bit keeps x + half-LSB from wrapping before the arithmetic shift.
    always_comb begin
        xs  = {x[ACC_WIDTH-1], x};
        rnd = '0;
        if (shift != 5'd0) rnd = SW'(1) << (shift - 5'd1);
        shifted = (xs + rnd) >>> shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   v_q <= '0;
        else if (clr) v_q <= '0;
        else if (en)  v_q <= shifted;
    end

    always_comb begin
        q = v_q[OUT_WIDTH-1:0];
        if (v_q > MAXV)      q = MAXV[OUT_WIDTH-1:0];
        else if (v_q < MINV) q = MINV[OUT_WIDTH-1:0];
`ifdef PACKER_RELU_EN
        if (v_q[SW-1]) q = '0;
`endif
    end
endmodule

module conv_result_packer #(
    parameter int ROI_SIZE     = 480,
    parameter int PORT_BITS    = 128,
    parameter int ACC_WIDTH    = 17,
    parameter int OUT_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int STALL_MARGIN = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          frame_clr,
    input  logic [4:0]                                    cfg_shift,
    input  logic                                          in_vld,
    input  logic [PORT_BITS/OUT_WIDTH-1:0][ACC_WIDTH-1:0] in_data,
    output logic                                          stall_req,
    output logic [PORT_BITS-1:0]                          out_data,
    output logic                                          out_vld,
    input  logic                                          out_rdy,
    output logic                                          out_last,
    output logic                                          out_frame_end,
    output logic                                          frame_done,
    output logic                                          ovf_err
);
    localparam int NPC = PORT_BITS / OUT_WIDTH;
    localparam int WPR = ROI_SIZE / NPC;
    localparam int CW  = $clog2(WPR);
    localparam int RW  = $clog2(ROI_SIZE);
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic                              beat_acc, wr_evt, wr_ok, rd, full;
    logic                              tag_last, tag_fend, head_fend;
    logic [1:0]                        vld_pipe;
    logic [NPC-1:0][OUT_WIDTH-1:0]     lane_q;
    logic [PORT_BITS-1:0]              s2_word;
    logic [CW-1:0]                     col_word;
    logic [RW-1:0]                     row;
    logic [PORT_BITS+1:0]              mem [FIFO_DEPTH];
    logic [AW-1:0]                     wr_ptr, rd_ptr;
    logic [AW:0]                       fifo_count;
    logic [AW+1:0]                     occ;

    assign beat_acc = in_vld && !frame_clr && (state != DRAIN);

    for (genvar n = 0; n < NPC; n++) begin : g_lane
        conv_requant_lane #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_lane (
            .clk(clk), .rst_n(rst_n), .clr(frame_clr), .en(beat_acc),
            .shift(cfg_shift), .x(in_data[n]), .q(lane_q[n])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s2_word  <= '0;
        end else if (frame_clr) begin
            vld_pipe <= '0;
            s2_word  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], beat_acc};
            if (vld_pipe[0]) s2_word <= lane_q;
        end
    end

    assign wr_evt   = vld_pipe[1];
    assign full     = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign rd       = out_vld && out_rdy;
    assign wr_ok    = wr_evt && (!full || rd);
    assign tag_last = (col_word == CW'(WPR - 1));
    assign tag_fend = tag_last && (row == RW'(ROI_SIZE - 1));

    // Counters move on every S2 write, dropped or not, so row alignment survives overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_word <= '0;
            row      <= '0;
        end else if (frame_clr) begin
            col_word <= '0;
            row      <= '0;
        end else if (wr_evt) begin
            col_word <= tag_last ? '0 : col_word + 1'b1;
            if (tag_last) row <= tag_fend ? '0 : row + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= {tag_fend, tag_last, s2_word};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (frame_clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd)    rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(wr_ok) - (AW+1)'(rd);
        end
    end

    assign out_vld       = (fifo_count != '0);
    assign out_data      = out_vld ? mem[rd_ptr][PORT_BITS-1:0] : '0;
    assign out_last      = out_vld && mem[rd_ptr][PORT_BITS];
    assign head_fend     = out_vld && mem[rd_ptr][PORT_BITS+1];
    assign out_frame_end = head_fend;
    assign frame_done    = (state == DRAIN) && rd && head_fend;

    assign occ       = (AW+2)'(fifo_count) + (AW+2)'(vld_pipe[0]) + (AW+2)'(vld_pipe[1]);
    assign stall_req = (occ >= (AW+2)'(FIFO_DEPTH - STALL_MARGIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ovf_err <= 1'b0;
        else if (frame_clr) ovf_err <= 1'b0;
        else if ((in_vld && state == DRAIN) || (wr_evt && full && !rd)) ovf_err <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         state <= IDLE;
        else if (frame_clr) state <= IDLE;
        else                state <= state_nxt;
    end

    // A dropped frame-end word can never be handshaked, so skip DRAIN in that case.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat_acc) state_nxt = RUN;
            RUN:     if (wr_evt && tag_fend) state_nxt = wr_ok ? DRAIN : IDLE;
            DRAIN:   if (rd && head_fend) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_conv_result_packer.sv
// Directed bench for conv_result_packer: requant values, latency, full frame tagging,
// stall/overflow behaviour and clear/reset recovery.
module tb_conv_result_packer;
    logic              clk = 1'b0;
    logic              rst_n, frame_clr, in_vld, out_rdy;
    logic [4:0]        cfg_shift;
    logic [15:0][16:0] in_data;
    logic              stall_req, out_vld, out_last, out_frame_end, frame_done, ovf_err;
    logic [127:0]      out_data;
    int                checks = 0;
    int                failures = 0;

`ifdef PACKER_RELU_EN
    localparam logic [7:0] E_NEG19 = 8'h00, E_NEG128 = 8'h00, E_NEG1 = 8'h00;
`else
    localparam logic [7:0] E_NEG19 = 8'hED, E_NEG128 = 8'h80, E_NEG1 = 8'hFF;
`endif

    conv_result_packer dut (
        .clk(clk), .rst_n(rst_n), .frame_clr(frame_clr), .cfg_shift(cfg_shift),
        .in_vld(in_vld), .in_data(in_data), .stall_req(stall_req), .out_data(out_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
        .out_frame_end(out_frame_end), .frame_done(frame_done), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic pulse_clr();
        in_vld = 1'b0;
        frame_clr = 1'b1;
        @(negedge clk);
        frame_clr = 1'b0;
        @(negedge clk);
    endtask

    // Streams n back-to-back beats (shift 0, lane0 = i%100) while collecting handshaked words.
    task automatic run_stream(input int n, output int words, output int first_last,
                              output int n_last, output int last_bad, output int fe_idx,
                              output int n_fe, output int n_done, output int data_bad);
        int w = 0, fl = -1, nl = 0, lb = 0, fi = -1, nf = 0, nd = 0, db = 0;
        cfg_shift = 5'd0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    in_vld = 1'b1;
                    in_data = '0;
                    in_data[0] = 17'(i % 100);
                    @(negedge clk);
                end
                in_vld = 1'b0;
            end
            begin
                for (int c = 0; c < n + 40 && w < n; c++) begin
                    @(negedge clk);
                    if (frame_done) nd++;
                    if (out_vld && out_rdy) begin
                        w++;
                        if (out_data[7:0] !== 8'((w - 1) % 100)) db++;
                        if (out_last !== (w % 30 == 0)) lb++;
                        if (out_last) begin
                            nl++;
                            if (fl < 0) fl = w;
                        end
                        if (out_frame_end) begin
                            nf++;
                            fi = w;
                        end
                    end
                end
            end
        join
        words = w; first_last = fl; n_last = nl; last_bad = lb;
        fe_idx = fi; n_fe = nf; n_done = nd; data_bad = db;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_clr = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        cfg_shift = 5'd0; in_data = '0;
        #12;
        checks++;
        if ({stall_req, out_vld, out_last, out_frame_end, frame_done, ovf_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000000",
                     {stall_req, out_vld, out_last, out_frame_end, frame_done, ovf_err});
        end
        checks++;
        if (out_data !== 128'd0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_requant();
        pulse_clr();
        cfg_shift = 5'd4;
        in_data = '0;
        in_data[0] = 17'sd200;
        in_data[1] = -17'sd300;
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        checks++;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL lat_t1 got=%b want=0", out_vld); end
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL lat_t2 got=%b want=0", out_vld); end
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1) begin failures++; $display("FAIL lat_t3 got=%b want=1", out_vld); end
        checks++;
        if (out_data[23:0] !== {8'h00, E_NEG19, 8'h0D}) begin
            failures++;
            $display("FAIL requant_s4 got=%h want=%h", out_data[23:0], {8'h00, E_NEG19, 8'h0D});
        end
        checks++;
        if (out_data[127:24] !== '0) begin
            failures++;
            $display("FAIL requant_upper got=%h want=0", out_data[127:24]);
        end
        @(negedge clk);
    endtask

    task automatic test_sat();
        pulse_clr();
        cfg_shift = 5'd2;
        in_data = '0;
        in_data[0] = 17'sd5000;
        in_data[1] = -17'sd5000;
        in_vld = 1'b1;
        @(negedge clk);
        cfg_shift = 5'd0;
        in_data = '0;
        in_data[2] = 17'h1FFFF;
        @(negedge clk);
        in_vld = 1'b0;
        out_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (out_data[15:0] !== {E_NEG128, 8'h7F}) begin
            failures++;
            $display("FAIL sat_s2 got=%h want=%h", out_data[15:0], {E_NEG128, 8'h7F});
        end
        out_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (out_data[23:0] !== {E_NEG1, 16'h0000}) begin
            failures++;
            $display("FAIL shift0_neg1 got=%h want=%h", out_data[23:0], {E_NEG1, 16'h0000});
        end
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        int w, fl, nl, lb, fi, nf, nd, db;
        pulse_clr();
        out_rdy = 1'b1;
        run_stream(14400, w, fl, nl, lb, fi, nf, nd, db);
        checks++;
        if (w !== 14400) begin failures++; $display("FAIL frame_words got=%0d want=14400", w); end
        checks++;
        if (nl !== 480 || lb !== 0) begin
            failures++;
            $display("FAIL frame_last got=%0d misplaced=%0d want=480 misplaced=0", nl, lb);
        end
        checks++;
        if (nf !== 1 || fi !== 14400) begin
            failures++;
            $display("FAIL frame_end got=%0d at %0d want=1 at 14400", nf, fi);
        end
        checks++;
        if (nd !== 1) begin failures++; $display("FAIL frame_done got=%0d want=1", nd); end
        checks++;
        if (db !== 0) begin failures++; $display("FAIL frame_data bad=%0d want=0", db); end
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0 || stall_req !== 1'b0 || ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL frame_idle got=%b%b%b want=000", out_vld, stall_req, ovf_err);
        end
        // Back in IDLE, a fresh row must be accepted from word 0.
        run_stream(30, w, fl, nl, lb, fi, nf, nd, db);
        checks++;
        if (w !== 30 || fl !== 30) begin
            failures++;
            $display("FAIL frame_restart got=%0d/%0d want=30/30", w, fl);
        end
    endtask

    task automatic test_stall();
        int n = 0, n_at_stall = -1;
        logic [7:0] got[$];
        pulse_clr();
        out_rdy = 1'b0;
        cfg_shift = 5'd0;
        for (int c = 0; c < 20; c++) begin
            if (stall_req && n_at_stall < 0) n_at_stall = n;
            if (!stall_req) begin
                in_vld = 1'b1;
                in_data = '0;
                in_data[0] = 17'(n + 1);
                n++;
            end else begin
                in_vld = 1'b0;
            end
            @(negedge clk);
        end
        in_vld = 1'b0;
        checks++;
        if (n_at_stall !== 6 || n !== 6) begin
            failures++;
            $display("FAIL stall_point got=%0d sent=%0d want=6 sent=6", n_at_stall, n);
        end
        checks++;
        if (ovf_err !== 1'b0 || stall_req !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold ovf=%b stall=%b want ovf=0 stall=1", ovf_err, stall_req);
        end
        out_rdy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_vld) got.push_back(out_data[7:0]);
            @(negedge clk);
        end
        checks++;
        if (got.size() !== 6) begin
            failures++;
            $display("FAIL stall_drain_cnt got=%0d want=6", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'(i + 1)) begin
                failures++;
                $display("FAIL stall_order[%0d] got=%0d want=%0d", i, got[i], i + 1);
            end
        end
        checks++;
        if (stall_req !== 1'b0) begin failures++; $display("FAIL stall_release got=1 want=0"); end
    endtask

    task automatic test_overflow();
        int w, fl, nl, lb, fi, nf, nd, db;
        logic [7:0] got[$];
        pulse_clr();
        out_rdy = 1'b0;
        cfg_shift = 5'd0;
        for (int c = 0; c < 14; c++) begin
            if (c == 10) begin
                checks++;
                if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_early got=1 want=0"); end
            end
            if (c == 11) begin
                checks++;
                if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_set got=0 want=1"); end
            end
            in_vld = (c < 10);
            in_data = '0;
            in_data[0] = 17'(c + 1);
            @(negedge clk);
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (out_vld) got.push_back(out_data[7:0]);
            @(negedge clk);
        end
        checks++;
        if (got.size() !== 8) begin
            failures++;
            $display("FAIL ovf_kept got=%0d want=8", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'(i + 1)) begin
                failures++;
                $display("FAIL ovf_order[%0d] got=%0d want=%0d", i, got[i], i + 1);
            end
        end
        // 10 words already counted in row 0, so the 20th further word closes the row.
        run_stream(20, w, fl, nl, lb, fi, nf, nd, db);
        checks++;
        if (fl !== 20) begin failures++; $display("FAIL ovf_align got=%0d want=20", fl); end
        checks++;
        if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=0 want=1"); end
        pulse_clr();
        checks++;
        if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_clr got=1 want=0"); end
    endtask

    task automatic test_clr_reset();
        int w, fl, nl, lb, fi, nf, nd, db;
        int seen = 0;
        pulse_clr();
        out_rdy = 1'b1;
        cfg_shift = 5'd0;
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1; in_data = '0; in_data[0] = 17'(i + 50);
            @(negedge clk);
        end
        frame_clr = 1'b1;
        in_data[0] = 17'd99;
        @(negedge clk);
        frame_clr = 1'b0;
        in_vld = 1'b0;
        checks++;
        if ({out_vld, stall_req, ovf_err, frame_done} !== 4'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL clr_state got=%b data=%h want=0000 data=0",
                     {out_vld, stall_req, ovf_err, frame_done}, out_data);
        end
        for (int c = 0; c < 5; c++) begin
            if (out_vld) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL clr_drop got=%0d want=0", seen); end
        run_stream(30, w, fl, nl, lb, fi, nf, nd, db);
        checks++;
        if (w !== 30 || fl !== 30 || db !== 0) begin
            failures++;
            $display("FAIL clr_realign got=%0d/%0d bad=%0d want=30/30 bad=0", w, fl, db);
        end
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_vld = 1'b1; in_data = '0; in_data[0] = 17'(i + 70);
            @(negedge clk);
        end
        in_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1) begin failures++; $display("FAIL rst_pre got=0 want=1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_vld, stall_req, ovf_err, out_last, out_frame_end} !== 5'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL rst_async got=%b data=%h want=00000 data=0",
                     {out_vld, stall_req, ovf_err, out_last, out_frame_end}, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_rdy = 1'b1;
        run_stream(30, w, fl, nl, lb, fi, nf, nd, db);
        checks++;
        if (w !== 30 || fl !== 30 || nf !== 0 || db !== 0) begin
            failures++;
            $display("FAIL rst_realign got=%0d/%0d fe=%0d bad=%0d want=30/30 fe=0 bad=0",
                     w, fl, nf, db);
        end
    endtask

    initial begin
        test_reset();
        test_requant();
        test_sat();
        test_full_frame();
        test_stall();
        test_overflow();
        test_clr_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
